// File: rtl/sid_output_stage_if.sv
// Voice-sample bus between the voice generator/DAC side and the SID output stage.
// Carries the per-sample controls in and the registered DAC sample out.
interface sid_output_stage_if;
  logic [11:0] din;
  logic [2:0]  cutoff;
  logic [7:0]  volume;
  logic        bypass;
  logic [11:0] dout;
  logic        dout_valid;
  logic        busy;

  modport master (output din, cutoff, volume, bypass, input dout, dout_valid, busy);
  modport slave  (input din, cutoff, volume, bypass, output dout, dout_valid, busy);
endinterface

// File: rtl/sid_output_stage.sv
// Decimate voice samples to one per DIV clocks, 1st-order IIR low-pass, serial volume multiply.
// Latency 10 clocks from capture to dout_valid; no backpressure, one sample per DIV clocks.
module sid_output_stage #(
  parameter int DIV  = 16,
  parameter int FRAC = 8
) (
  input logic              clk,
  input logic              rst_n,
  sid_output_stage_if.slave bus
);
  localparam int HALF = 1 << (FRAC - 1);

  typedef enum logic [1:0] {IDLE, FILT, MUL, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic        tick;

  logic [11:0] din_s;
  logic [2:0]  k_s;
  logic [7:0]  vol_s;
  logic        byp_s;

  logic [20:0] acc;
  logic [11:0] y;
  logic [19:0] prod, mcand;
  logic [7:0]  mplier;
  logic [2:0]  bit_cnt;
  logic [11:0] dout_r;
  logic        dout_valid_r;

  logic signed [21:0] target, diff, half_k, rnd, step;
  logic [20:0]        acc_new;
  logic [21:0]        y_wide, y_sh;
  logic [11:0]        y_next;

  assign tick           = (cnt == 16'(DIV - 1));
  assign bus.busy       = (state != IDLE);
  assign bus.dout       = dout_r;
  assign bus.dout_valid = dout_valid_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      state <= IDLE;
    end else begin
      cnt   <= tick ? '0 : cnt + 16'd1;
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tick) state_nxt = FILT;
      FILT:    state_nxt = MUL;
      MUL:     if (bit_cnt == 3'd7) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Rounded arithmetic-shift step keeps acc within [-63,+64] of the target once settled.
  always_comb begin
    target = $signed(22'(din_s) << FRAC);
    diff   = target - $signed({1'b0, acc});
    half_k = 22'sd1 <<< (k_s - 3'd1);
    rnd    = diff + half_k;
    step   = rnd >>> k_s;
    if (byp_s || k_s == 3'd0) acc_new = 21'(din_s) << FRAC;
    else                      acc_new = 21'($signed({1'b0, acc}) + step);
    y_wide = {1'b0, acc_new} + 22'(HALF);
    y_sh   = y_wide >> FRAC;
    y_next = (y_sh > 22'd4095) ? 12'd4095 : y_sh[11:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_s        <= '0;
      k_s          <= '0;
      vol_s        <= '0;
      byp_s        <= 1'b0;
      acc          <= '0;
      y            <= '0;
      prod         <= '0;
      mcand        <= '0;
      mplier       <= '0;
      bit_cnt      <= '0;
      dout_r       <= '0;
      dout_valid_r <= 1'b0;
    end else begin
      dout_valid_r <= 1'b0;
      case (state)
        IDLE: if (tick) begin
          din_s <= bus.din;
          k_s   <= bus.cutoff;
          vol_s <= bus.volume;
          byp_s <= bus.bypass;
        end
        FILT: begin
          acc     <= acc_new;
          y       <= y_next;
          mcand   <= {8'd0, y_next};
          mplier  <= vol_s;
          prod    <= '0;
          bit_cnt <= '0;
        end
        MUL: begin
          if (mplier[0]) prod <= prod + mcand;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          bit_cnt <= bit_cnt + 3'd1;
        end
        DONE: begin
          // Full-scale volume is exact unity rather than 255/256.
          dout_r       <= (vol_s == 8'd255) ? y : prod[19:8];
          dout_valid_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  a_no_tick_while_busy: assert property (@(posedge clk) disable iff (!rst_n) !(tick && state != IDLE));
endmodule

// File: tb/tb_sid_output_stage.sv
// Directed bench for sid_output_stage: sample-level reference model plus literal spot checks.
module tb_sid_output_stage;
  localparam int DIV = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sid_output_stage_if bus();
  sid_output_stage #(.DIV(DIV), .FRAC(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: one filter/volume evaluation per tick, result due 10 clocks later.
  int m_phase, m_left, m_pend, m_acc, m_dout;
  bit m_valid;

  function automatic int floor_div(input int t, input int d);
    if (t >= 0) return t / d;
    return -((-t + d - 1) / d);
  endfunction

  function automatic int model_sample(input int d, input int k, input int v, input bit b);
    int yy;
    if (b || k == 0) m_acc = d * 256;
    else             m_acc = m_acc + floor_div(d * 256 - m_acc + (1 << (k - 1)), 1 << k);
    yy = (m_acc + 128) / 256;
    if (yy > 4095) yy = 4095;
    return (v == 255) ? yy : (yy * v) / 256;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit tick_now;
    if (!rst_n) begin
      m_phase = 0; m_left = 0; m_pend = 0; m_acc = 0; m_dout = 0; m_valid = 0;
    end else begin
      tick_now = (m_phase == DIV - 1);
      m_phase  = (m_phase + 1) % DIV;
      m_valid  = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_dout  = m_pend;
          m_valid = 1;
        end
      end
      if (tick_now) begin
        m_pend = model_sample(bus.din, bus.cutoff, bus.volume, bus.bypass);
        m_left = 10;
      end
    end
  end

  always @(negedge clk) begin
    #1;
    check("dout", bus.dout, m_dout);
    check("dout_valid", bus.dout_valid, m_valid);
    check("busy", bus.busy, m_left > 0);
  end

  task automatic set_in(input int d, input int k, input int v, input bit b);
    bus.din = 12'(d); bus.cutoff = 3'(k); bus.volume = 8'(v); bus.bypass = b;
  endtask

  // Counts falling edges until busy (sel=0) or dout_valid (sel=1) is seen high.
  task automatic count_until(input string name, input bit sel, output int n);
    logic s;
    n = 0;
    do begin
      @(negedge clk); #2; n++;
      s = sel ? bus.dout_valid : bus.busy;
    end while (s !== 1'b1 && n < 100);
    if (s !== 1'b1) begin
      check({name, "_timeout"}, 0, 1);
      n = -1;
    end
  endtask

  task automatic wait_valid(input string name, output int val);
    int n;
    count_until(name, 1'b1, n);
    val = (n < 0) ? -1 : int'(bus.dout);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.din = 12'($urandom);
      #2;
      check("rst_dout", bus.dout, 0);
      check("rst_valid", bus.dout_valid, 0);
      check("rst_busy", bus.busy, 0);
    end
  endtask

  task automatic release_reset();
    @(negedge clk); #2; rst_n = 1'b1;
  endtask

  initial begin
    int n, v;
    bit over;
    set_in(0, 0, 255, 0);
    #1 rst_n = 1'b0;

    // Reset, first-tick timing and pass-through
    do_reset();
    set_in(12'hABC, 0, 255, 0);
    release_reset();
    count_until("first_busy", 1'b0, n);
    check("first_busy_cycle", n, 16);
    count_until("first_valid", 1'b1, n);
    check("first_valid_delay", n, 10);
    check("pass_through", bus.dout, 12'hABC);
    @(negedge clk); #2;
    check("valid_one_cycle", bus.dout_valid, 0);
    count_until("second_valid", 1'b1, n);
    check("valid_period", n, 15);
    check("pass_through2", bus.dout, 12'hABC);

    // Filter step response k=1, then soak
    do_reset();
    set_in(4000, 1, 255, 0);
    release_reset();
    wait_valid("step1", v); check("step1", v, 2000);
    wait_valid("step2", v); check("step2", v, 3000);
    wait_valid("step3", v); check("step3", v, 3500);
    over = 0;
    for (int i = 0; i < 30; i++) begin
      wait_valid("soak_k1", v);
      if (v > 4000) over = 1;
    end
    check("no_overshoot", over, 0);
    check("soak_k1_final", v, 4000);
    set_in(4095, 7, 255, 0);
    for (int i = 0; i < 1000; i++) wait_valid("soak_k7", v);
    check("soak_k7_final", v, 4095);

    // Volume with bypass
    set_in(4000, 0, 128, 1); wait_valid("vol128", v); wait_valid("vol128", v); check("vol128", v, 2000);
    set_in(4000, 0, 0, 1);   wait_valid("vol0", v);   check("vol0", v, 0);
    set_in(4000, 0, 255, 1); wait_valid("vol255", v); check("vol255", v, 4000);
    set_in(4000, 0, 1, 1);   wait_valid("vol1", v);   check("vol1", v, 15);

    // Sampling isolation
    set_in(100, 0, 255, 1);
    wait_valid("iso_pre", v);
    count_until("iso_capture", 1'b0, n);
    set_in(300, 0, 128, 1);
    wait_valid("iso_inflight", v); check("iso_inflight", v, 100);
    wait_valid("iso_next", v);     check("iso_next", v, 150);

    // Asynchronous reset in the middle of the multiply
    set_in(500, 0, 255, 1);
    count_until("mid_capture", 1'b0, n);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_dout", bus.dout, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_valid", bus.dout_valid, 0);
    repeat (3) @(negedge clk);
    release_reset();
    count_until("restart_busy", 1'b0, n);
    check("restart_busy_cycle", n, 16);
    wait_valid("restart_val", v); check("restart_val", v, 500);

    repeat (2) @(negedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
